// File: rtl/lib_cpu.sv
// rtl/lib_cpu.sv - shared loader/receiver state types and stream constants
package lib_cpu;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_SUM,
        S_DONE,
        S_ERR
    } loader_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    localparam int LEN_BYTES = 4;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 receiver: 2-FF synchronizer, mid-bit sampling, framing check
module uart_rx
    import lib_cpu::*;
#(
    parameter int WAIT = 3125000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int CW = $clog2(WAIT + 1);
    localparam logic [CW-1:0] FULL = CW'(WAIT - 1);
    localparam logic [CW-1:0] HALF = CW'(WAIT / 2 - 1);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta_q, rx_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    // IDLE is only re-entered with the line high, so a low level here is a falling edge
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        valid     = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_sync_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        valid   = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                cnt_d = '0;
                if (rx_sync_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data = shift_q;

endmodule

// File: rtl/uart_rom_loader.sv
// rtl/uart_rom_loader.sv - loads a length-prefixed word image from UART into ROM, then releases the CPU
// Optional trailing XOR checksum byte: LOADER_CHECKSUM_EN
module uart_rom_loader
    import lib_cpu::*;
#(
    parameter int WAIT   = 3125000,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_e LOAD_END = S_SUM;
`else
    localparam loader_state_e LOAD_END = S_DONE;
`endif

    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err;

    uart_rx #(.WAIT(WAIT)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (uart_rx),
        .data      (rx_data),
        .valid     (rx_valid),
        .frame_err (rx_frame_err)
    );

    loader_state_e     state_q, state_d;
    logic [1:0]        byte_q, byte_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W:0]   len_q, len_d, cnt_q, cnt_d;
    logic              we_q, we_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic [31:0] word_next;
    logic        last_byte;

    assign word_next = {rx_data, word_q[31:8]};
    assign last_byte = (byte_q == 2'(LEN_BYTES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LEN;
            byte_q  <= '0;
            word_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        word_d  = word_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q | rx_frame_err;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (rx_valid && (state_q == S_LEN || state_q == S_DATA)) begin
            byte_d = byte_q + 2'd1;
            word_d = word_next;
`ifdef LOADER_CHECKSUM_EN
            sum_d  = sum_q ^ rx_data;
`endif
        end
        case (state_q)
            S_LEN: begin
                if (rx_frame_err) begin
                    state_d = S_ERR;
                end else if (rx_valid && last_byte) begin
                    len_d = word_next[ADDR_W:0];
                    if (word_next > MAX_LEN) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (word_next == '0) begin
                        state_d = LOAD_END;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            // leave one cycle after the final write so done trails the last rom_we
            S_DATA: begin
                if (rx_frame_err) begin
                    state_d = S_ERR;
                end else if (we_q && cnt_q == len_q) begin
                    state_d = LOAD_END;
                end else if (rx_valid && last_byte) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = word_next;
                    cnt_d   = cnt_q + (ADDR_W + 1)'(1);
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_SUM: begin
                if (rx_frame_err) begin
                    state_d = S_ERR;
                end else if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: state_d = state_q;
        endcase
    end

    assign rom_we    = we_q;
    assign rom_addr  = addr_q;
    assign rom_wdata = wdata_q;
    assign done      = (state_q == S_DONE);
    assign cpu_reset = (state_q != S_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// tb/tb_uart_rom_loader.sv - randomized loader bench against a stream-level reference model
module tb_uart_rom_loader;

    localparam int WAIT   = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;
    // start-bit drive to byte_valid: 2-FF sync, edge detect, half bit, 8 data bits, stop bit
    localparam int LAT    = 2 + WAIT / 2 + 9 * WAIT;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              uart_rx = 1'b1;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;
    logic              cpu_reset, done, err;

    uart_rom_loader #(.WAIT(WAIT), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         got_q[$], exp_q[$];
    logic [7:0]  bytes_q[$];
    int          start_q[$];
    logic [31:0] words_q[$];
    logic [7:0]  sum_flip = 8'h00;
    int          done_cyc = -1, rel_cyc = -1, exp_done_cyc;
    bit          exp_done, exp_err;
    int          n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rom_we) got_q.push_back('{cyc: cyc, addr: int'(rom_addr), data: rom_wdata});
            if (done && done_cyc < 0) done_cyc = cyc;
            if (!cpu_reset && rel_cyc < 0) rel_cyc = cyc;
        end
    end

    task automatic apply_reset(input string name);
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_eq({name, ".rst_we"}, rom_we, 0);
        check_eq({name, ".rst_addr"}, rom_addr, 0);
        check_eq({name, ".rst_wdata"}, rom_wdata, 0);
        check_eq({name, ".rst_cpu_reset"}, cpu_reset, 1);
        check_eq({name, ".rst_done"}, done, 0);
        check_eq({name, ".rst_err"}, err, 0);
        got_q.delete();
        done_cyc = -1;
        rel_cyc  = -1;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop);
        @(negedge clk);
        start_q.push_back(cyc);
        uart_rx = 1'b0;
        repeat (WAIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (WAIT) @(negedge clk);
        end
        uart_rx = good_stop;
        repeat (WAIT) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Interprets the byte stream as a loader would: length, N words, optional checksum.
    task automatic run_model(input int bad_idx);
        logic [31:0] len;
        logic [7:0]  sum;
        int          avail, last;
`ifdef LOADER_CHECKSUM_EN
        int          k;
`endif
        exp_q.delete();
        exp_done     = 1'b0;
        exp_err      = (bad_idx >= 0);
        exp_done_cyc = -1;
        avail = (bad_idx >= 0) ? bad_idx : bytes_q.size();
        if (avail < 4) return;
        len = {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]};
        sum = bytes_q[0] ^ bytes_q[1] ^ bytes_q[2] ^ bytes_q[3];
        if (len > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < int'(len); w++) begin
            int b;
            b = 4 + 4 * w;
            if (b + 4 > avail) return;
            exp_q.push_back('{cyc: start_q[b+3] + LAT + 1, addr: w,
                              data: {bytes_q[b+3], bytes_q[b+2], bytes_q[b+1], bytes_q[b]}});
            sum = sum ^ bytes_q[b] ^ bytes_q[b+1] ^ bytes_q[b+2] ^ bytes_q[b+3];
        end
        last = (len == 0) ? start_q[3] + LAT + 1 : exp_q[$].cyc + 1;
`ifdef LOADER_CHECKSUM_EN
        k = 4 + 4 * int'(len);
        if (k >= avail) return;
        if (bytes_q[k] != sum) begin
            exp_err = 1'b1;
            return;
        end
        last = start_q[k] + LAT + 1;
`endif
        exp_done     = 1'b1;
        exp_done_cyc = last;
    endtask

    task automatic verify(input string name);
        check_eq({name, ".we_count"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                check_eq($sformatf("%s.addr%0d", name, i), got_q[i].addr, exp_q[i].addr);
                check_eq($sformatf("%s.data%0d", name, i), got_q[i].data, exp_q[i].data);
                check_eq($sformatf("%s.we_cyc%0d", name, i), got_q[i].cyc, exp_q[i].cyc);
            end
        end
        check_eq({name, ".done"}, done, exp_done);
        check_eq({name, ".err"}, err, exp_err);
        check_eq({name, ".cpu_reset"}, cpu_reset, !exp_done);
        check_eq({name, ".done_cyc"}, done_cyc, exp_done_cyc);
        check_eq({name, ".release_cyc"}, rel_cyc, exp_done_cyc);
        if (exp_q.size() > 0) begin
            check_eq({name, ".hold_addr"}, rom_addr, exp_q[$].addr);
            check_eq({name, ".hold_data"}, rom_wdata, exp_q[$].data);
        end
    endtask

    task automatic run_load(input string name, input logic [31:0] len, input int n_extra,
                            input int bad_idx);
        logic [7:0] sum;
        bytes_q.delete();
        start_q.delete();
        for (int i = 0; i < 4; i++) bytes_q.push_back(len[8*i +: 8]);
        foreach (words_q[w]) for (int i = 0; i < 4; i++) bytes_q.push_back(words_q[w][8*i +: 8]);
        sum = 8'h00;
        foreach (bytes_q[i]) sum = sum ^ bytes_q[i];
`ifdef LOADER_CHECKSUM_EN
        bytes_q.push_back(sum ^ sum_flip);
`endif
        for (int i = 0; i < n_extra; i++) bytes_q.push_back(8'($urandom));
        foreach (bytes_q[i]) begin
            if (bad_idx >= 0 && i > bad_idx) break;
            send_byte(bytes_q[i], i != bad_idx);
        end
        repeat (4) @(negedge clk);
        run_model(bad_idx);
        verify(name);
    endtask

    initial begin
        apply_reset("por");

        words_q = '{32'h54311101};
        run_load("one_word", 32'd1, 0, -1);

        apply_reset("r1");
        words_q = '{32'h54311101, 32'h12345678, 32'h12345678, 32'h12345678, 32'h54322201};
        run_load("five_words", 32'd5, 0, -1);

        apply_reset("r2");
        words_q.delete();
        run_load("zero_len", 32'd0, 0, -1);

        apply_reset("r3");
        run_load("len_overflow", 32'd17, 4, -1);

        apply_reset("r4");
        words_q = '{32'hA5A5_0001, 32'h0BAD_F00D};
        run_load("bad_stop", 32'd2, 0, 5);
        apply_reset("r5");
        run_load("reload", 32'd2, 0, -1);

        apply_reset("r6");
        @(negedge clk) uart_rx = 1'b0;
        @(negedge clk) uart_rx = 1'b1;
        repeat (3 * WAIT) @(negedge clk);
        check_eq("glitch.we_count", got_q.size(), 0);
        check_eq("glitch.done", done, 0);
        check_eq("glitch.err", err, 0);
        check_eq("glitch.cpu_reset", cpu_reset, 1);
        words_q = '{32'hCAFE_BEEF};
        run_load("after_glitch", 32'd1, 0, -1);

        apply_reset("r7");
        words_q = '{32'h1111_2222, 32'h3333_4444};
        bytes_q = '{8'd2, 8'd0, 8'd0, 8'd0, 8'h22, 8'h22, 8'h11, 8'h11, 8'h44, 8'h44};
        foreach (bytes_q[i]) send_byte(bytes_q[i], 1'b1);
        @(negedge clk) uart_rx = 1'b0;
        repeat (3 * WAIT) @(negedge clk);
        check_eq("abort.we_count", got_q.size(), 1);
        apply_reset("r8");

        for (int r = 0; r < 3; r++) begin
            int n;
            n = (r == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            words_q.delete();
            for (int w = 0; w < n; w++) words_q.push_back($urandom);
            run_load($sformatf("rand%0d", r), n, int'($urandom_range(0, 2)), -1);
            apply_reset($sformatf("rr%0d", r));
        end

`ifdef LOADER_CHECKSUM_EN
        words_q  = '{32'h12345678};
        sum_flip = 8'h00;
        run_load("sum_ok", 32'd1, 0, -1);
        apply_reset("r9");
        sum_flip = 8'h01;
        run_load("sum_bad", 32'd1, 0, -1);
        sum_flip = 8'h00;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
